// File: rtl/mem_line_pkg.sv
// Shared types and size helpers for the cache-line to beat-bus serializer.
//   state_e        : serializer FSM states
//   NUM_BEATS etc. : values for the default 512-bit line / 64-bit beat geometry
//   calc_*         : derive the same values for any parameterization
package mem_line_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    WDATA = 3'd2,
    RDATA = 3'd3,
    ACK   = 3'd4
  } state_e;

  localparam int unsigned CMD_LEN_W     = 8;
  localparam int unsigned NUM_BEATS     = 512 / 64;
  localparam int unsigned BEAT_IDX_W    = $clog2(NUM_BEATS);
  localparam int unsigned LINE_OFFSET_W = $clog2(512 / 8);

  function automatic int unsigned calc_num_beats(input int unsigned line_w,
                                                 input int unsigned beat_w);
    return line_w / beat_w;
  endfunction

  function automatic int unsigned calc_beat_idx_w(input int unsigned num_beats);
    return $clog2(num_beats);
  endfunction

  function automatic int unsigned calc_line_offset_w(input int unsigned line_w);
    return $clog2(line_w / 8);
  endfunction

endpackage

// File: rtl/mem_line_watchdog.sv
// Progress watchdog: counts consecutive active cycles with no handshake.
//   clk, rst     : clock, asynchronous active-high reset
//   i_active     : serializer is in a transfer state
//   i_progress   : some handshake completes this cycle (clears the count)
//   o_expire_c   : combinational pulse in the TIMEOUT_CYCLES-th stalled cycle
module mem_line_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_progress,
  output logic o_expire_c
);

  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit          ENABLED = (TIMEOUT_CYCLES != 0);

  logic [CNT_W-1:0] r_cnt;

  // r_cnt holds the number of stalled cycles already elapsed before this one
  assign o_expire_c = ENABLED && i_active && !i_progress && (r_cnt == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_active || i_progress || o_expire_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_line_serializer.sv
// Converts one cache-line request into a single burst on a narrow
// command / write-beat / read-beat valid-ready bus.
//   line_*      : upstream line port (req held until line_ack)
//   cmd_*       : burst command channel (line-aligned address, len = beats-1)
//   wr_*        : write beats, least-significant slice first
//   rd_*        : read beats, assembled into line_rdata
//   busy, err_protocol, err_timeout, line_count : status
module mem_line_serializer
  import mem_line_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned LINE_WIDTH     = 512,
  parameter int unsigned BEAT_WIDTH     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] line_addr,
  input  logic [LINE_WIDTH-1:0] line_wdata,
  input  logic                  line_req,
  input  logic                  line_we,
  output logic                  line_ack,
  output logic [LINE_WIDTH-1:0] line_rdata,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic                  cmd_we,
  output logic [CMD_LEN_W-1:0]  cmd_len,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [BEAT_WIDTH-1:0] wr_data,
  output logic                  wr_last,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [BEAT_WIDTH-1:0] rd_data,
  input  logic                  rd_last,
  output logic                  busy,
  output logic                  err_protocol,
  output logic                  err_timeout,
  output logic [31:0]           line_count
);

  localparam int unsigned NB     = calc_num_beats(LINE_WIDTH, BEAT_WIDTH);
  localparam int unsigned BIDX_W = calc_beat_idx_w(NB);
  localparam int unsigned OFF_W  = calc_line_offset_w(LINE_WIDTH);
  localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(NB - 1);

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_cmd_addr;
  logic                  r_cmd_we;
  logic                  r_cmd_valid;
  logic [CMD_LEN_W-1:0]  r_cmd_len;
  logic                  r_wr_valid;
  logic                  r_wr_last;
  logic [BEAT_WIDTH-1:0] r_wr_data;
  logic                  r_rd_ready;
  logic                  r_line_ack;
  logic [LINE_WIDTH-1:0] r_line_rdata;
  logic [LINE_WIDTH-1:0] r_line;
  logic [BIDX_W-1:0]     r_beat;
  logic                  r_busy;
  logic                  r_err_protocol;
  logic                  r_err_timeout;
  logic [31:0]           r_line_count;

  logic                  w_cmd_hs;
  logic                  w_wr_hs;
  logic                  w_rd_hs;
  logic                  w_active;
  logic                  w_expire;
  logic                  w_beat_last;
  logic [BIDX_W-1:0]     w_beat_nxt;
  logic [LINE_WIDTH-1:0] w_line_upd;
  logic                  w_unused_addr;

  assign w_cmd_hs    = r_cmd_valid & cmd_ready;
  assign w_wr_hs     = r_wr_valid & wr_ready;
  assign w_rd_hs     = r_rd_ready & rd_valid;
  assign w_active    = (r_state == CMD) || (r_state == WDATA) || (r_state == RDATA);
  assign w_beat_last = (r_beat == LAST_BEAT);
  assign w_beat_nxt  = r_beat + BIDX_W'(1);
  // Offset bits inside the line are dropped when the address is aligned
  assign w_unused_addr = ^line_addr[OFF_W-1:0];

  // Working line with the current read beat merged into its slot
  always_comb begin
    w_line_upd = r_line;
    w_line_upd[int'(r_beat) * BEAT_WIDTH +: BEAT_WIDTH] = rd_data;
  end

  mem_line_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_active  (w_active),
    .i_progress(w_cmd_hs | w_wr_hs | w_rd_hs),
    .o_expire_c(w_expire)
  );

  // Serializer FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cmd_addr     <= '0;
      r_cmd_we       <= 1'b0;
      r_cmd_valid    <= 1'b0;
      r_cmd_len      <= '0;
      r_wr_valid     <= 1'b0;
      r_wr_last      <= 1'b0;
      r_wr_data      <= '0;
      r_rd_ready     <= 1'b0;
      r_line_ack     <= 1'b0;
      r_line_rdata   <= '0;
      r_line         <= '0;
      r_beat         <= '0;
      r_busy         <= 1'b0;
      r_err_protocol <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_line_count   <= '0;
    end else begin
      r_line_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (line_req) begin
            r_cmd_addr  <= {line_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
            r_cmd_we    <= line_we;
            r_cmd_len   <= CMD_LEN_W'(NB - 1);
            // Reads start from the previous line so a timeout leaves untouched slots intact
            r_line      <= line_we ? line_wdata : r_line_rdata;
            r_cmd_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= CMD;
          end
        end
        CMD: begin
          if (w_expire) begin
            r_cmd_valid   <= 1'b0;
            r_err_timeout <= 1'b1;
            r_line_ack    <= 1'b1;
            r_state       <= ACK;
          end else if (w_cmd_hs) begin
            r_cmd_valid <= 1'b0;
            r_beat      <= '0;
            if (r_cmd_we) begin
              r_wr_valid <= 1'b1;
              r_wr_data  <= r_line[BEAT_WIDTH-1:0];
              r_wr_last  <= 1'b0;
              r_state    <= WDATA;
            end else begin
              r_rd_ready <= 1'b1;
              r_state    <= RDATA;
            end
          end
        end
        WDATA: begin
          if (w_expire) begin
            r_wr_valid    <= 1'b0;
            r_wr_last     <= 1'b0;
            r_err_timeout <= 1'b1;
            r_line_ack    <= 1'b1;
            r_state       <= ACK;
          end else if (w_wr_hs) begin
            if (w_beat_last) begin
              r_wr_valid <= 1'b0;
              r_wr_last  <= 1'b0;
              r_line_ack <= 1'b1;
              r_state    <= ACK;
            end else begin
              r_beat    <= w_beat_nxt;
              r_wr_data <= r_line[int'(w_beat_nxt) * BEAT_WIDTH +: BEAT_WIDTH];
              r_wr_last <= (w_beat_nxt == LAST_BEAT);
            end
          end
        end
        RDATA: begin
          if (w_expire) begin
            r_rd_ready    <= 1'b0;
            r_line_rdata  <= r_line;
            r_err_timeout <= 1'b1;
            r_line_ack    <= 1'b1;
            r_state       <= ACK;
          end else if (w_rd_hs) begin
            r_line <= w_line_upd;
            // The beat counter, not rd_last, decides completion
            if (rd_last != w_beat_last) begin
              r_err_protocol <= 1'b1;
            end
            if (w_beat_last) begin
              r_rd_ready   <= 1'b0;
              r_line_rdata <= w_line_upd;
              r_line_ack   <= 1'b1;
              r_state      <= ACK;
            end else begin
              r_beat <= w_beat_nxt;
            end
          end
        end
        ACK: begin
          r_line_count <= r_line_count + 32'd1;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign line_ack     = r_line_ack;
  assign line_rdata   = r_line_rdata;
  assign cmd_valid    = r_cmd_valid;
  assign cmd_addr     = r_cmd_addr;
  assign cmd_we       = r_cmd_we;
  assign cmd_len      = r_cmd_len;
  assign wr_valid     = r_wr_valid;
  assign wr_data      = r_wr_data;
  assign wr_last      = r_wr_last;
  assign rd_ready     = r_rd_ready;
  assign busy         = r_busy;
  assign err_protocol = r_err_protocol;
  assign err_timeout  = r_err_timeout;
  assign line_count   = r_line_count;

endmodule

// File: tb/tb_mem_line_serializer.sv
// Directed bench for mem_line_serializer (512-bit line, 64-bit beats, 16-cycle watchdog).
module tb_mem_line_serializer;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 512;
  localparam int unsigned BW = 64;
  localparam int unsigned NB = 8;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] line_addr;
  logic [LW-1:0] line_wdata;
  logic          line_req;
  logic          line_we;
  logic          line_ack;
  logic [LW-1:0] line_rdata;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          cmd_we;
  logic [7:0]    cmd_len;
  logic          wr_valid;
  logic          wr_ready;
  logic [BW-1:0] wr_data;
  logic          wr_last;
  logic          rd_valid;
  logic          rd_ready;
  logic [BW-1:0] rd_data;
  logic          rd_last;
  logic          busy;
  logic          err_protocol;
  logic          err_timeout;
  logic [31:0]   line_count;

  always #5 clk = ~clk;

  mem_line_serializer #(
    .ADDR_WIDTH    (AW),
    .LINE_WIDTH    (LW),
    .BEAT_WIDTH    (BW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .line_addr   (line_addr),
    .line_wdata  (line_wdata),
    .line_req    (line_req),
    .line_we     (line_we),
    .line_ack    (line_ack),
    .line_rdata  (line_rdata),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_we      (cmd_we),
    .cmd_len     (cmd_len),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .busy        (busy),
    .err_protocol(err_protocol),
    .err_timeout (err_timeout),
    .line_count  (line_count)
  );

  int            n_cmp = 0;
  int            n_mis = 0;
  logic [BW-1:0] got_data [0:15];
  logic          got_last [0:15];
  int            got_n;
  int            ack_n;
  logic          cv_at_ack;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Upstream write plus a memory-side sink with optional command delay and toggling wr_ready
  task automatic do_write(input logic [AW-1:0] addr, input logic [LW-1:0] line,
                          input int cmd_delay, input bit toggle, input logic [AW-1:0] exp_addr);
    int            cmd_wait;
    bit            seen_cmd;
    bit            prev_stall;
    logic [BW-1:0] prev_data;
    cmd_wait = 0; seen_cmd = 0; prev_stall = 0; prev_data = '0;
    got_n = 0; ack_n = -1; cv_at_ack = 1'bx;
    line_addr = addr; line_wdata = line; line_we = 1'b1; line_req = 1'b1;
    for (int n = 1; n <= 100 && ack_n < 0; n++) begin
      step();
      if (line_ack) begin
        ack_n = n; cv_at_ack = cmd_valid;
        line_req = 1'b0; cmd_ready = 1'b0; wr_ready = 1'b0;
      end else begin
        cmd_ready = 1'b0;
        if (cmd_valid) begin
          if (!seen_cmd) begin
            seen_cmd = 1;
            chk("wr_cmd_addr", cmd_addr, exp_addr);
            chk("wr_cmd_len", cmd_len, 8'd7);
            chk("wr_cmd_we", cmd_we, 1'b1);
          end
          cmd_ready = (cmd_wait >= cmd_delay);
          cmd_wait++;
        end
        wr_ready = 1'b0;
        if (wr_valid) begin
          if (prev_stall) chk("wr_stable", wr_data, prev_data);
          wr_ready = toggle ? n[0] : 1'b1;
          if (wr_ready && got_n < 16) begin
            got_data[got_n] = wr_data; got_last[got_n] = wr_last; got_n++;
          end
          prev_stall = !wr_ready; prev_data = wr_data;
        end
      end
    end
    step();
    chk("wr_ack_pulse", line_ack, 1'b0);
    chk("wr_idle_busy", busy, 1'b0);
  endtask

  // Upstream read plus a memory-side source; rd_last also on bad_last; stops after max_beats
  task automatic do_read(input logic [AW-1:0] addr, input logic [LW-1:0] line,
                         input int bad_last, input int max_beats, input logic [AW-1:0] exp_addr);
    int k;
    bit seen_cmd;
    k = 0; seen_cmd = 0; ack_n = -1;
    line_addr = addr; line_we = 1'b0; line_req = 1'b1;
    for (int n = 1; n <= 100 && ack_n < 0; n++) begin
      step();
      if (line_ack) begin
        ack_n = n; line_req = 1'b0; rd_valid = 1'b0; rd_last = 1'b0;
      end else begin
        cmd_ready = cmd_valid;
        if (cmd_valid && !seen_cmd) begin
          seen_cmd = 1;
          chk("rd_cmd_addr", cmd_addr, exp_addr);
          chk("rd_cmd_we", cmd_we, 1'b0);
        end
        rd_valid = 1'b0; rd_last = 1'b0;
        if (rd_ready) begin
          if (k == max_beats) return;
          rd_valid = 1'b1;
          rd_data  = line[k*BW +: BW];
          rd_last  = (k == NB - 1) || (k == bad_last);
          k++;
        end
      end
    end
    step();
    chk("rd_ack_pulse", line_ack, 1'b0);
    chk("rd_idle_busy", busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [LW-1:0] wline, wline2, rline, rline2, rline3;
    for (int i = 0; i < NB; i++) begin
      wline [i*BW +: BW] = 64'hC0DE_0000_0000_0000 | 64'(i);
      wline2[i*BW +: BW] = 64'h5A5A_0000_0000_0000 | (64'(i) << 8);
      rline [i*BW +: BW] = 64'hA0 + 64'(i);
      rline2[i*BW +: BW] = 64'hB0 + 64'(i);
      rline3[i*BW +: BW] = 64'hC0 + 64'(i);
    end

    rst = 1'b1; line_addr = '0; line_wdata = '0; line_req = 1'b0; line_we = 1'b0;
    cmd_ready = 1'b0; wr_ready = 1'b0; rd_valid = 1'b0; rd_data = '0; rd_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_wr_valid", wr_valid, 1'b0);
    chk("rst_rd_ready", rd_ready, 1'b0);
    chk("rst_line_ack", line_ack, 1'b0);
    chk("rst_line_count", line_count, 32'd0);
    chk("rst_line_rdata", line_rdata, '0);
    chk("rst_errs", {err_protocol, err_timeout}, 2'b00);
    rst = 1'b0;
    step();

    // Plain write: ack in the 11th cycle counting the request cycle
    do_write(32'h0000_1234, wline, 0, 0, 32'h0000_1200);
    chk("w1_ack_lat", ack_n, 10);
    chk("w1_nbeats", got_n, 8);
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("w1_beat%0d", i), got_data[i], wline[i*BW +: BW]);
      chk($sformatf("w1_last%0d", i), got_last[i], (i == NB - 1));
    end
    chk("w1_count", line_count, 32'd1);
    chk("w1_rdata_kept", line_rdata, '0);

    // Plain read
    do_read(32'h8000_0040, rline, -1, 8, 32'h8000_0040);
    chk("r1_ack_lat", ack_n, 10);
    chk("r1_rdata", line_rdata, rline);
    chk("r1_err_protocol", err_protocol, 1'b0);
    chk("r1_count", line_count, 32'd2);

    // Command held off 5 cycles, write beats accepted every other cycle
    do_write(32'h0000_ABFF, wline2, 5, 1, 32'h0000_ABC0);
    chk("w2_ack_lat", ack_n, 22);
    chk("w2_nbeats", got_n, 8);
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("w2_beat%0d", i), got_data[i], wline2[i*BW +: BW]);
      chk($sformatf("w2_last%0d", i), got_last[i], (i == NB - 1));
    end
    chk("w2_count", line_count, 32'd3);
    chk("w2_err_timeout", err_timeout, 1'b0);

    // Early rd_last on beat 3
    do_read(32'h0000_3000, rline2, 3, 8, 32'h0000_3000);
    chk("r2_ack_lat", ack_n, 10);
    chk("r2_err_protocol", err_protocol, 1'b1);
    chk("r2_rdata", line_rdata, rline2);
    chk("r2_count", line_count, 32'd4);

    // Clean read afterwards: error flag stays set
    do_read(32'h0000_3047, rline3, -1, 8, 32'h0000_3040);
    chk("r3_ack_lat", ack_n, 10);
    chk("r3_err_sticky", err_protocol, 1'b1);
    chk("r3_rdata", line_rdata, rline3);
    chk("r3_count", line_count, 32'd5);

    // Command never accepted: watchdog fires after 16 stalled CMD cycles
    do_write(32'h0000_0100, wline, 1000, 0, 32'h0000_0100);
    chk("to_ack_lat", ack_n, 17);
    chk("to_cmd_valid_at_ack", cv_at_ack, 1'b0);
    chk("to_nbeats", got_n, 0);
    chk("to_err_timeout", err_timeout, 1'b1);
    chk("to_count", line_count, 32'd6);
    chk("to_rdata_kept", line_rdata, rline3);

    // Reset in the middle of a read (four beats taken)
    do_read(32'h0000_2000, rline, -1, 4, 32'h0000_2000);
    chk("mid_rd_ready", rd_ready, 1'b1);
    line_req = 1'b0; rd_valid = 1'b0; cmd_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar_busy", busy, 1'b0);
    chk("ar_rd_ready", rd_ready, 1'b0);
    chk("ar_cmd_valid", cmd_valid, 1'b0);
    chk("ar_line_ack", line_ack, 1'b0);
    chk("ar_line_count", line_count, 32'd0);
    chk("ar_line_rdata", line_rdata, '0);
    chk("ar_errs", {err_protocol, err_timeout}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    step();

    do_read(32'h0000_2040, rline2, -1, 8, 32'h0000_2040);
    chk("r4_ack_lat", ack_n, 10);
    chk("r4_rdata", line_rdata, rline2);
    chk("r4_count", line_count, 32'd1);
    chk("r4_errs", {err_protocol, err_timeout}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_line_serializer.md
Name: mem_line_serializer

Overview:
Downstream neighbour of the system top's external memory port: consumes the 512-bit cache-line request (addr/wdata/req/we, rdata/ack) issued by the unified memory controller. Converts each line transfer into one burst on a narrower valid/ready beat bus (command, write-beat and read-beat channels) toward the off-chip memory PHY/fabric. One line in flight at a time. Includes a progress watchdog, sticky error flags and a completed-line counter.

Parameters:
ADDR_WIDTH, 32, byte address width
LINE_WIDTH, 512, cache-line width in bits
BEAT_WIDTH, 64, beat-bus data width; NUM_BEATS = LINE_WIDTH/BEAT_WIDTH, power of two, >= 2
TIMEOUT_CYCLES, 1024, idle-progress watchdog limit; 0 disables

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
line_addr  in  ADDR_WIDTH  line byte address
line_wdata  in  LINE_WIDTH  write line
line_req  in  1  request, held until line_ack
line_we  in  1  1 = write line, 0 = read line
line_ack  out  1  one-cycle completion pulse
line_rdata  out  LINE_WIDTH  read line, valid with line_ack, held until next read completes
cmd_valid  out  1  burst command valid
cmd_ready  in  1  command accepted
cmd_addr  out  ADDR_WIDTH  line-aligned burst address
cmd_we  out  1  burst direction
cmd_len  out  8  beats minus one (NUM_BEATS-1)
wr_valid  out  1  write beat valid
wr_ready  in  1  write beat accepted
wr_data  out  BEAT_WIDTH  write beat
wr_last  out  1  final write beat
rd_valid  in  1  read beat valid
rd_ready  out  1  read beat accepted
rd_data  in  BEAT_WIDTH  read beat
rd_last  in  1  final read beat marker
busy  out  1  state != IDLE
err_protocol  out  1  sticky: rd_last mismatch
err_timeout  out  1  sticky: watchdog expired
line_count  out  32  completed lines, wraps at 2^32

Behaviour:
- Reset (asynchronous, any state): state IDLE; every output 0; line_rdata, line_count, beat counter, watchdog cleared; sticky flags cleared. An in-flight burst is abandoned with no further beat-bus activity.
- Clocking/reset: one clock clk; reset rst is asynchronous and active-high.
- IDLE: on line_req=1, capture line_addr with low log2(LINE_WIDTH/8) bits forced to 0, plus line_wdata and line_we -> CMD. No combinational input-to-output paths.
- CMD: cmd_valid=1; cmd_addr/cmd_we/cmd_len stable until cmd_ready. On handshake -> WDATA if we, else RDATA; beat counter = 0.
- WDATA: wr_valid=1; wr_data = line[beat*BEAT_WIDTH +: BEAT_WIDTH], beat 0 = least-significant slice; wr_last=1 iff beat=NUM_BEATS-1. Counter increments on wr_valid&wr_ready; final handshake -> ACK.
- RDATA: rd_ready=1; on rd_valid, rd_data stored into line slot [beat]. rd_last=1 on a non-final beat, or rd_last=0 on the final beat, sets err_protocol; the counter still governs completion. Final beat -> ACK.
- ACK: line_ack=1 for exactly one cycle. For reads, line_rdata updates on the ACK-entry edge; writes leave line_rdata unchanged. line_count += 1 -> IDLE.
- Upstream deasserts line_req in the cycle after line_ack. A req still high in IDLE is a new request. Minimum line latency: write 1+1+NUM_BEATS+1 cycles; read is the same.
- Watchdog: counts cycles in CMD/WDATA/RDATA without a handshake; any handshake resets it. At TIMEOUT_CYCLES: set err_timeout, drop all beat-bus valid/ready, go to ACK. A read completes with partially updated line_rdata.
- Beat counter: log2(NUM_BEATS) bits. It reaches NUM_BEATS-1 without wrapping mid-burst.

Decomposition:
- Package mem_line_pkg: state enum (IDLE, CMD, WDATA, RDATA, ACK), derived NUM_BEATS, BEAT_IDX_W, LINE_OFFSET_W, CMD_LEN_W=8.
- Optional single sub-module mem_line_watchdog (counter, clear-on-progress, expire pulse). Datapath and FSM stay in the top module.

Test Plan:
- Write 0x0000_1234, line = beats 0..7 = 64'h0..7 patterns, cmd/wr_ready always 1 -> cmd_addr=0x0000_1200, cmd_len=7, eight wr beats in order, wr_last on 8th, line_ack 11 cycles after req, line_count=1.
- Read 0x8000_0040, rd beats 64'hA0..A7, rd_last on 8th -> line_rdata[63:0]=A0 ... [511:448]=A7, err_protocol=0.
- Backpressure: wr_ready toggling 1/0 and cmd_ready delayed 5 cycles -> wr_data stable while stalled, no beat lost or duplicated.
- rd_last asserted on beat 3 -> err_protocol=1 and sticky, transfer still completes after 8 beats with one line_ack.
- TIMEOUT_CYCLES=16, cmd_ready held 0 -> err_timeout at cycle 16 in CMD, cmd_valid drops, single line_ack.
- Reset asserted mid-RDATA (beat 4) -> all outputs 0 immediately, busy=0. A new read after reset completes normally.
